// File: rtl/deco_reg_bank_if.sv
// Bus bundle for deco_reg_bank: write strobe/select/data in, committed registers and status out.
// Optional DECO_REG_DIRECT_EN adds the 'direct' bypass control.
interface deco_reg_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 3
);
    localparam int SEL_W = $clog2(CHANNELS + 1);

`ifdef DECO_REG_DIRECT_EN
    logic                      direct;
`endif
    logic [SEL_W-1:0]          sel;
    logic                      load;
    logic [WIDTH-1:0]          data_in;
    logic                      ready;
    logic [CHANNELS*WIDTH-1:0] data_out;
    logic                      done;
    logic                      seq_err;
    logic [SEL_W-1:0]          fill_level;

    modport master (
`ifdef DECO_REG_DIRECT_EN
        output direct,
`endif
        output sel, load, data_in,
        input  ready, data_out, done, seq_err, fill_level
    );

    modport slave (
`ifdef DECO_REG_DIRECT_EN
        input  direct,
`endif
        input  sel, load, data_in,
        output ready, data_out, done, seq_err, fill_level
    );
endinterface

// File: rtl/deco_reg_bank.sv
// Decoder-register bank: ordered writes fill a shadow bank that is committed atomically to data_out.
// Optional feature macro: DECO_REG_DIRECT_EN (direct per-channel writes, bypassing sequencing).
module deco_reg_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 3
) (
    input  logic              clk,
    input  logic              reset,
    deco_reg_bank_if.slave    bus
);
    localparam int SEL_W = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_e;

    state_e                           state_q, state_d;
    logic [SEL_W-1:0]                 exp_q, exp_d;
    logic [SEL_W-1:0]                 fill_q, fill_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   data_out_q, data_out_d;
    logic                             done_q, done_d;
    logic                             seq_err_q, seq_err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        exp_d      = exp_q;
        fill_d     = fill_q;
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        seq_err_d  = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (bus.load) begin
                    if (bus.sel == exp_q) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (exp_q == SEL_W'(k + 1)) shadow_d[k] = bus.data_in;
                        end
                        fill_d = exp_q;
                        if (exp_q == SEL_W'(CHANNELS)) begin
                            state_d = COMMIT;
                            exp_d   = SEL_W'(1);
                        end else begin
                            state_d = FILL;
                            exp_d   = exp_q + SEL_W'(1);
                        end
                    end else if (state_q == FILL && bus.sel == SEL_W'(1)) begin
                        // A fresh channel 1 mid-sequence restarts rather than errors.
                        shadow_d[0] = bus.data_in;
                        exp_d       = SEL_W'(2);
                        fill_d      = SEL_W'(1);
                        state_d     = FILL;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = IDLE;
                        exp_d     = SEL_W'(1);
                        fill_d    = '0;
                    end
                end
            end
            COMMIT: begin
                data_out_d = shadow_q;
                done_d     = 1'b1;
                fill_d     = '0;
                exp_d      = SEL_W'(1);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                exp_d   = SEL_W'(1);
                fill_d  = '0;
            end
        endcase

`ifdef DECO_REG_DIRECT_EN
        // Direct mode overrides sequencing entirely; the shadow bank is left untouched.
        if (bus.direct) begin
            state_d    = IDLE;
            exp_d      = SEL_W'(1);
            fill_d     = '0;
            shadow_d   = shadow_q;
            data_out_d = data_out_q;
            done_d     = 1'b0;
            seq_err_d  = 1'b0;
            if (bus.load) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (bus.sel == SEL_W'(k + 1)) data_out_d[k] = bus.data_in;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= IDLE;
            exp_q      <= SEL_W'(1);
            fill_q     <= '0;
            // NOTE: the shadow bank is small and must read as zero after reset, so it is reset too.
            shadow_q   <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            fill_q     <= fill_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign bus.ready      = (state_q != COMMIT);
    assign bus.data_out   = data_out_q;
    assign bus.done       = done_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.fill_level = fill_q;
endmodule

// File: tb/tb_deco_reg_bank.sv
// Directed testbench for deco_reg_bank (WIDTH=4, CHANNELS=3); define DECO_REG_DIRECT_EN to cover direct mode.
module tb_deco_reg_bank;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    deco_reg_bank_if #(.WIDTH(4), .CHANNELS(3)) bus ();

    deco_reg_bank #(.WIDTH(4), .CHANNELS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [3:0] d, input logic l);
        bus.sel     = s;
        bus.data_in = d;
        bus.load    = l;
    endtask

    task automatic test_reset();
        reset = 1'b1;
`ifdef DECO_REG_DIRECT_EN
        bus.direct = 1'b0;
`endif
        drive(2'd0, 4'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL reset_data_out: got %h want 000", bus.data_out); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err: got %b want 0", bus.seq_err); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", bus.fill_level); end
    endtask

    task automatic test_ordered();
        drive(2'd1, 4'h1, 1'b1); step();
        total++; if (bus.fill_level !== 2'd1) begin bad++; $display("FAIL ord_fill1: got %0d want 1", bus.fill_level); end
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL ord_hold1: got %h want 000", bus.data_out); end
        drive(2'd2, 4'h2, 1'b1); step();
        total++; if (bus.fill_level !== 2'd2) begin bad++; $display("FAIL ord_fill2: got %0d want 2", bus.fill_level); end
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL ord_hold2: got %h want 000", bus.data_out); end
        drive(2'd3, 4'h3, 1'b1); step();
        total++; if (bus.fill_level !== 2'd3) begin bad++; $display("FAIL ord_fill3: got %0d want 3", bus.fill_level); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL ord_commit_ready: got %b want 0", bus.ready); end
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL ord_hold3: got %h want 000", bus.data_out); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ord_done_early: got %b want 0", bus.done); end
        drive(2'd0, 4'h0, 1'b0); step();
        total++; if (bus.data_out !== 12'h321) begin bad++; $display("FAIL ord_commit: got %h want 321", bus.data_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ord_done: got %b want 1", bus.done); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL ord_fill0: got %0d want 0", bus.fill_level); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL ord_ready_back: got %b want 1", bus.ready); end
        step();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ord_done_pulse: got %b want 0", bus.done); end
        total++; if (bus.data_out !== 12'h321) begin bad++; $display("FAIL ord_keep: got %h want 321", bus.data_out); end
    endtask

    task automatic test_back_to_back();
        drive(2'd1, 4'hF, 1'b1); step();
        drive(2'd2, 4'hE, 1'b1); step();
        drive(2'd3, 4'hD, 1'b1); step();
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got %b want 0", bus.ready); end
        drive(2'd1, 4'h1, 1'b1); step();
        total++; if (bus.data_out !== 12'hDEF) begin bad++; $display("FAIL b2b_commit: got %h want DEF", bus.data_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL b2b_dropped: got %0d want 0", bus.fill_level); end
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL b2b_silent_drop: got %b want 0", bus.seq_err); end
        drive(2'd1, 4'h1, 1'b1); step();
        total++; if (bus.fill_level !== 2'd1) begin bad++; $display("FAIL b2b_resend: got %0d want 1", bus.fill_level); end
        drive(2'd2, 4'h2, 1'b1); step();
        drive(2'd3, 4'h3, 1'b1); step();
        drive(2'd0, 4'h0, 1'b0); step();
        total++; if (bus.data_out !== 12'h321) begin bad++; $display("FAIL b2b_second: got %h want 321", bus.data_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done2: got %b want 1", bus.done); end
        step();
    endtask

    task automatic test_out_of_order();
        drive(2'd1, 4'hA, 1'b1); step();
        total++; if (bus.fill_level !== 2'd1) begin bad++; $display("FAIL ooo_fill1: got %0d want 1", bus.fill_level); end
        drive(2'd3, 4'hB, 1'b1); step();
        total++; if (bus.seq_err !== 1'b1) begin bad++; $display("FAIL ooo_err: got %b want 1", bus.seq_err); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL ooo_fill0: got %0d want 0", bus.fill_level); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ooo_done: got %b want 0", bus.done); end
        total++; if (bus.data_out !== 12'h321) begin bad++; $display("FAIL ooo_keep: got %h want 321", bus.data_out); end
        drive(2'd1, 4'h7, 1'b0); step();
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL ooo_err_pulse: got %b want 0", bus.seq_err); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL ooo_noload: got %0d want 0", bus.fill_level); end
        drive(2'd0, 4'h7, 1'b1); step();
        total++; if (bus.seq_err !== 1'b1) begin bad++; $display("FAIL ooo_sel0: got %b want 1", bus.seq_err); end
        drive(2'd2, 4'h7, 1'b1); step();
        total++; if (bus.seq_err !== 1'b1) begin bad++; $display("FAIL ooo_idle_sel2: got %b want 1", bus.seq_err); end
        drive(2'd0, 4'h0, 1'b0); step();
        total++; if (bus.data_out !== 12'h321) begin bad++; $display("FAIL ooo_keep2: got %h want 321", bus.data_out); end
    endtask

    task automatic test_restart();
        drive(2'd1, 4'h5, 1'b1); step();
        drive(2'd1, 4'h6, 1'b1); step();
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL rst_no_err: got %b want 0", bus.seq_err); end
        total++; if (bus.fill_level !== 2'd1) begin bad++; $display("FAIL rst_fill: got %0d want 1", bus.fill_level); end
        drive(2'd2, 4'h7, 1'b1); step();
        total++; if (bus.fill_level !== 2'd2) begin bad++; $display("FAIL rst_fill2: got %0d want 2", bus.fill_level); end
        drive(2'd3, 4'h8, 1'b1); step();
        drive(2'd0, 4'h0, 1'b0); step();
        total++; if (bus.data_out !== 12'h876) begin bad++; $display("FAIL rst_commit: got %h want 876", bus.data_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rst_done: got %b want 1", bus.done); end
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL rst_no_err2: got %b want 0", bus.seq_err); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(2'd1, 4'h4, 1'b1); step();
        drive(2'd2, 4'h5, 1'b1); step();
        total++; if (bus.fill_level !== 2'd2) begin bad++; $display("FAIL mid_fill2: got %0d want 2", bus.fill_level); end
        reset = 1'b1;
        drive(2'd3, 4'h6, 1'b1); step();
        reset = 1'b0;
        drive(2'd0, 4'h0, 1'b0);
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL mid_data: got %h want 000", bus.data_out); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL mid_fill0: got %0d want 0", bus.fill_level); end
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.ready); end
        step();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_no_done: got %b want 0", bus.done); end
        total++; if (bus.data_out !== 12'h000) begin bad++; $display("FAIL mid_no_commit: got %h want 000", bus.data_out); end
        drive(2'd1, 4'h9, 1'b1); step();
        drive(2'd2, 4'hA, 1'b1); step();
        drive(2'd3, 4'hB, 1'b1); step();
        drive(2'd0, 4'h0, 1'b0); step();
        total++; if (bus.data_out !== 12'hBA9) begin bad++; $display("FAIL mid_commit: got %h want BA9", bus.data_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mid_done: got %b want 1", bus.done); end
        step();
    endtask

`ifdef DECO_REG_DIRECT_EN
    task automatic test_direct();
        bus.direct = 1'b1;
        drive(2'd2, 4'h9, 1'b1); step();
        total++; if (bus.data_out !== 12'hB99) begin bad++; $display("FAIL dir_write: got %h want B99", bus.data_out); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dir_done: got %b want 0", bus.done); end
        total++; if (bus.fill_level !== 2'd0) begin bad++; $display("FAIL dir_fill: got %0d want 0", bus.fill_level); end
        drive(2'd0, 4'h5, 1'b1); step();
        total++; if (bus.data_out !== 12'hB99) begin bad++; $display("FAIL dir_sel0: got %h want B99", bus.data_out); end
        total++; if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL dir_no_err: got %b want 0", bus.seq_err); end
        bus.direct = 1'b0;
        drive(2'd0, 4'h0, 1'b0); step();
    endtask
`endif

    initial begin
        test_reset();
        test_ordered();
        test_back_to_back();
        test_out_of_order();
        test_restart();
        test_reset_mid();
`ifdef DECO_REG_DIRECT_EN
        test_direct();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
